// File: rtl/gyro_pkg.sv
// gyro_pkg: shared state encoding, rate type and saturation limits for the gyro bias calibrator
package gyro_pkg;
  typedef enum logic [1:0] {CAL_IDLE, CAL_RUN_CAL, CAL_RUN} cal_state_t;
  typedef logic signed [15:0] rate_t;
  localparam int RATE_MAX = 32767;
  localparam int RATE_MIN = -32768;
endpackage

// File: rtl/gyro_bias_calibrator_if.sv
// gyro_bias_calibrator_if: raw sample input and corrected rate output bundle
interface gyro_bias_calibrator_if;
  import gyro_pkg::*;
  logic  cal_start_in;
  logic  raw_valid_in;
  rate_t gx_raw_in;
  rate_t gy_raw_in;
  rate_t gz_raw_in;
  rate_t gx_out;
  rate_t gy_out;
  rate_t gz_out;
  logic  valid_out;
  logic  cal_busy_out;
  logic  cal_done_out;
  modport master (
    output cal_start_in, raw_valid_in, gx_raw_in, gy_raw_in, gz_raw_in,
    input  gx_out, gy_out, gz_out, valid_out, cal_busy_out, cal_done_out
  );
  modport slave (
    input  cal_start_in, raw_valid_in, gx_raw_in, gy_raw_in, gz_raw_in,
    output gx_out, gy_out, gz_out, valid_out, cal_busy_out, cal_done_out
  );
endinterface

// File: rtl/gyro_axis_cal.sv
// gyro_axis_cal: per-axis bias accumulator, bias register, saturating subtract; deadband under GYRO_DEADBAND_EN
module gyro_axis_cal import gyro_pkg::*; #(
  parameter int CAL_LOG2 = 4,
  parameter int DEADBAND = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr_i,
  input  logic  acc_en_i,
  input  logic  commit_i,
  input  logic  out_en_i,
  input  rate_t raw_i,
  output rate_t out_o
);
  localparam int AW = 16 + CAL_LOG2;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [16:0] diff;
  rate_t bias_q, out_q, sat, out_d;
  assign acc_d = acc_q + {{CAL_LOG2{raw_i[15]}}, raw_i};
  assign diff  = $signed({raw_i[15], raw_i}) - $signed({bias_q[15], bias_q});
  assign sat   = (diff > 17'(RATE_MAX)) ? rate_t'(RATE_MAX) :
                 (diff < 17'(RATE_MIN)) ? rate_t'(RATE_MIN) : diff[15:0];
`ifdef GYRO_DEADBAND_EN
  logic signed [16:0] se, mag;
  assign se    = {sat[15], sat};
  assign mag   = sat[15] ? -se : se;
  assign out_d = (mag < 17'(DEADBAND)) ? '0 : sat;
`else
  logic unused_deadband;
  assign unused_deadband = (DEADBAND != 0);
  assign out_d = sat;
`endif
  assign out_o = out_q;
  // accumulate during calibration, floor-average into the bias on the final sample, register corrected output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q  <= '0;
      bias_q <= '0;
      out_q  <= '0;
    end else begin
      if (clr_i) acc_q <= '0;
      else if (acc_en_i) acc_q <= acc_d;
      if (commit_i) bias_q <= rate_t'(acc_d >>> CAL_LOG2);
      if (out_en_i) out_q <= out_d;
    end
endmodule

// File: rtl/gyro_bias_calibrator.sv
// gyro_bias_calibrator: calibration FSM, sample counter and strobes around three gyro_axis_cal; optional GYRO_DEADBAND_EN
module gyro_bias_calibrator import gyro_pkg::*; #(
  parameter int CAL_LOG2 = 4,
  parameter int DEADBAND = 8
) (
  input logic clk_100mhz,
  input logic rst_in,
  gyro_bias_calibrator_if.slave bus
);
  localparam int CW = CAL_LOG2 + 1;
  cal_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic valid_q, busy_q, done_q, clr, acc_en, out_en, last;
  rate_t raw [3];
  rate_t cor [3];
  assign clr    = bus.cal_start_in && state_q != CAL_RUN_CAL;
  assign acc_en = bus.raw_valid_in && state_q == CAL_RUN_CAL;
  assign out_en = bus.raw_valid_in && state_q != CAL_RUN_CAL;
  assign last   = acc_en && cnt_q == CW'((1 << CAL_LOG2) - 1);
  assign raw    = '{bus.gx_raw_in, bus.gy_raw_in, bus.gz_raw_in};
  for (genvar i = 0; i < 3; i++) begin : g_axis
    gyro_axis_cal #(.CAL_LOG2(CAL_LOG2), .DEADBAND(DEADBAND)) u_axis (
      .clk(clk_100mhz), .rst_n(rst_in), .clr_i(clr), .acc_en_i(acc_en),
      .commit_i(last), .out_en_i(out_en), .raw_i(raw[i]), .out_o(cor[i])
    );
  end
  assign bus.gx_out       = cor[0];
  assign bus.gy_out       = cor[1];
  assign bus.gz_out       = cor[2];
  assign bus.valid_out    = valid_q;
  assign bus.cal_busy_out = busy_q;
  assign bus.cal_done_out = done_q;
  // state machine with registered valid/busy/done strobes; start is ignored while calibrating
  always_ff @(posedge clk_100mhz or negedge rst_in)
    if (!rst_in) begin
      state_q <= CAL_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= out_en;
      done_q  <= 1'b0;
      if (clr) begin
        state_q <= CAL_RUN_CAL;
        busy_q  <= 1'b1;
        cnt_q   <= '0;
      end else if (acc_en) begin
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          state_q <= CAL_RUN;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_gyro_bias_calibrator.sv
// tb_gyro_bias_calibrator: directed and randomized checks against a floor-average/clamp reference model
module tb_gyro_bias_calibrator;
  localparam int N  = 16;
  localparam int DB = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int bias [3] = '{0, 0, 0};
  int eo [3] = '{0, 0, 0};
  int sx [$];
  int sy [$];
  int sz [$];
  gyro_bias_calibrator_if bus();
  gyro_bias_calibrator #(.CAL_LOG2(4), .DEADBAND(DB)) dut (
    .clk_100mhz(clk), .rst_in(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int fdiv(input int s, input int n);
    return (s >= 0) ? s / n : -((-s + n - 1) / n);
  endfunction

  function automatic int model(input int raw, input int b);
    int d;
    d = raw - b;
    d = (d > 32767) ? 32767 : (d < -32768) ? -32768 : d;
`ifdef GYRO_DEADBAND_EN
    if ((d < 0 ? -d : d) < DB) d = 0;
`endif
    return d;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic strobe(input int x, input int y, input int z, input bit st);
    @(negedge clk);
    bus.gx_raw_in = 16'(x);
    bus.gy_raw_in = 16'(y);
    bus.gz_raw_in = 16'(z);
    bus.raw_valid_in = 1'b1;
    bus.cal_start_in = st;
    @(negedge clk);
    bus.raw_valid_in = 1'b0;
    bus.cal_start_in = 1'b0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_gx"}, int'($signed(bus.gx_out)), eo[0]);
    chk({tag, "_gy"}, int'($signed(bus.gy_out)), eo[1]);
    chk({tag, "_gz"}, int'($signed(bus.gz_out)), eo[2]);
  endtask

  task automatic run(input string tag, input int x, input int y, input int z);
    strobe(x, y, z, 1'b0);
    eo = '{model(x, bias[0]), model(y, bias[1]), model(z, bias[2])};
    chk_outs(tag);
    chk({tag, "_valid"}, int'(bus.valid_out), 1);
    @(negedge clk);
    chk({tag, "_valid_drop"}, int'(bus.valid_out), 0);
    chk_outs({tag, "_hold"});
  endtask

  task automatic cal(input string tag, input bit coincident);
    int s [3];
    if (coincident) begin
      strobe(11, 22, 33, 1'b1);
      eo = '{model(11, bias[0]), model(22, bias[1]), model(33, bias[2])};
      chk_outs({tag, "_coinc_out"});
      chk({tag, "_coinc_valid"}, int'(bus.valid_out), 1);
    end else begin
      @(negedge clk);
      bus.cal_start_in = 1'b1;
      @(negedge clk);
      bus.cal_start_in = 1'b0;
    end
    chk({tag, "_busy_start"}, int'(bus.cal_busy_out), 1);
    s = '{0, 0, 0};
    for (int k = 0; k < N; k++) begin
      strobe(sx[k], sy[k], sz[k], k == 3);
      s[0] += sx[k];
      s[1] += sy[k];
      s[2] += sz[k];
      if (k < N - 1) begin
        chk({tag, "_valid_low"}, int'(bus.valid_out), 0);
        chk({tag, "_busy"}, int'(bus.cal_busy_out), 1);
        chk({tag, "_done_early"}, int'(bus.cal_done_out), 0);
      end
    end
    chk({tag, "_done"}, int'(bus.cal_done_out), 1);
    chk({tag, "_busy_end"}, int'(bus.cal_busy_out), 0);
    chk({tag, "_valid_end"}, int'(bus.valid_out), 0);
    chk_outs({tag, "_outs_held"});
    for (int a = 0; a < 3; a++) bias[a] = fdiv(s[a], N);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(bus.cal_done_out), 0);
  endtask

  task automatic fill(input int x, input int y, input int z, input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      sx.push_back(x);
      sy.push_back(y);
      sz.push_back(z);
    end
  endtask

  initial begin
    bus.cal_start_in = 1'b0;
    bus.raw_valid_in = 1'b0;
    bus.gx_raw_in = '0;
    bus.gy_raw_in = '0;
    bus.gz_raw_in = '0;
    #12;
    eo = '{0, 0, 0};
    chk_outs("reset");
    chk("reset_valid", int'(bus.valid_out), 0);
    chk("reset_busy", int'(bus.cal_busy_out), 0);
    chk("reset_done", int'(bus.cal_done_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run("t1", 100, -7, 0);
    sx.delete(); sy.delete(); sz.delete();
    fill(100, -5, 3, 0, N);
    cal("t2", 1'b0);
    run("t2_run", 150, 0, 3);
    run("t3_sat", -32768, 32767, 0);
    sx.delete(); sy.delete(); sz.delete();
    fill(-3, -3, -3, 0, 8);
    fill(-2, -2, -2, 8, 16);
    cal("t4", 1'b0);
    chk("t4_bias_model", bias[0], -3);
    run("t4_run", 0, 0, 0);
    @(negedge clk);
    bus.cal_start_in = 1'b1;
    @(negedge clk);
    bus.cal_start_in = 1'b0;
    for (int k = 0; k < 7; k++) strobe(500, 500, 500, 1'b0);
    rst_n = 1'b0;
    #1;
    bias = '{0, 0, 0};
    eo = '{0, 0, 0};
    chk_outs("t5_rst");
    chk("t5_rst_busy", int'(bus.cal_busy_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run("t5_run", 100, 100, 100);
    run("t6_a", 7, -7, 0);
    run("t6_b", -8, 8, 9);
    run("t6_c", 9, -9, -32768);
    sx.delete(); sy.delete(); sz.delete();
    fill(40, -40, 1000, 0, N);
    cal("t6_coinc", 1'b1);
    run("t6_coinc_run", 40, -40, 1000);
    for (int r = 0; r < 4; r++) begin
      int b [3];
      for (int a = 0; a < 3; a++) b[a] = int'($urandom_range(40000)) - 20000;
      sx.delete(); sy.delete(); sz.delete();
      for (int k = 0; k < N; k++) begin
        sx.push_back(b[0] + int'($urandom_range(200)) - 100);
        sy.push_back(b[1] + int'($urandom_range(200)) - 100);
        sz.push_back(b[2] + int'($urandom_range(200)) - 100);
      end
      cal("rnd_cal", 1'b0);
      for (int k = 0; k < 6; k++) run("rnd_run", rnd16(), rnd16(), rnd16());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
